// File: rtl/cp0_irq_ctrl.sv
// cp0_irq_ctrl: CP0 SR/Cause/EPC/PRId with NUM_IRQ masked interrupt entry and eret return sequencing
module cp0_irq_ctrl #(
  parameter int          NUM_IRQ      = 6,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID         = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] hwint,
  input  logic [31:0]        pc_F,
  input  logic [31:0]        pc_D,
  input  logic [31:0]        pc_E,
  input  logic [31:0]        pc_M,
  input  logic               valid_D,
  input  logic               valid_E,
  input  logic               valid_M,
  input  logic               bd_D,
  input  logic               bd_E,
  input  logic               bd_M,
  input  logic               eret_M,
  input  logic               cp0_we,
  input  logic [4:0]         cp0_addr,
  input  logic [31:0]        cp0_wdata,
  output logic [31:0]        cp0_rdata,
  output logic               int_req,
  output logic               eret_req,
  output logic [31:0]        redirect_pc,
  output logic [31:0]        epc,
  output logic               exl
);
  typedef enum logic [1:0] {IDLE, HANDLER, RESUME} state_t;
  state_t             state;
  logic [NUM_IRQ-1:0] im, ip;
  logic               ie, exl_q, bd;
  logic [31:2]        epc_q;
  logic [31:0]        victim_pc, victim_adj, sr_val, cause_val;
  logic               victim_bd, unused_ok;
  always_comb begin
    victim_pc   = valid_M ? pc_M : valid_E ? pc_E : valid_D ? pc_D : pc_F;
    victim_bd   = valid_M ? bd_M : valid_E ? bd_E : valid_D & bd_D;
    victim_adj  = victim_bd ? victim_pc - 32'd4 : victim_pc;
    int_req     = ie & ~exl_q & |(hwint & im) & (state == IDLE) & ~eret_M;
    eret_req    = eret_M & (state != RESUME);
    redirect_pc = int_req ? HANDLER_ADDR : eret_req ? {epc_q, 2'b00} : '0;
    sr_val      = {{(22-NUM_IRQ){1'b0}}, im, 8'b0, exl_q, ie};
    cause_val   = {bd, {(21-NUM_IRQ){1'b0}}, ip, 10'b0};
    cp0_rdata   = cp0_addr == 5'd12 ? sr_val :
                  cp0_addr == 5'd13 ? cause_val :
                  cp0_addr == 5'd14 ? {epc_q, 2'b00} :
                  cp0_addr == 5'd15 ? PRID : '0;
  end
  assign epc       = {epc_q, 2'b00};
  assign exl       = exl_q;
  assign unused_ok = ^{cp0_wdata, victim_adj[1:0]};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      im    <= '0;
      ip    <= '0;
      ie    <= 1'b0;
      exl_q <= 1'b0;
      bd    <= 1'b0;
      epc_q <= '0;
    end else begin
      ip <= hwint;
      if (int_req) begin
        epc_q <= victim_adj[31:2];
        bd    <= victim_bd;
        exl_q <= 1'b1;
        state <= HANDLER;
      end else if (eret_req) begin
        exl_q <= 1'b0;
        state <= RESUME;
      end else begin
        if (state == RESUME) state <= IDLE;
        if (cp0_we && cp0_addr == 5'd12) begin
          im    <= cp0_wdata[10 +: NUM_IRQ];
          exl_q <= cp0_wdata[1];
          ie    <= cp0_wdata[0];
        end
        if (cp0_we && cp0_addr == 5'd14) epc_q <= cp0_wdata[31:2];
      end
    end
  end
endmodule
